// File: rtl/ball_engine.sv
// ball_engine: per-frame ball motion for the Pong datapath.
// Bounces off the top/bottom walls and both paddles, deflects by paddle third,
// ramps speed every HITS_PER_SPEEDUP paddle hits, detects misses and runs
// the serve/play/point sequence.
//
// Ports
//   clk, reset                 clock, asynchronous active-high reset
//   x_i, y_i                   current VGA pixel
//   pause_i                    freezes all frame-tick updates
//   padl_*_i / padr_*_i        left/right paddle bounds (t, b, l, r), inclusive
//   ball_on_o                  pixel (x_i, y_i) lies inside the ball
//   ball_x_o, ball_y_o         ball left/top edge
//   speed_o                    horizontal speed in pixels/frame
//   state_o                    0 SERVE, 1 PLAY, 2 POINT
//   score_l_o, score_r_o       one-clk scoring pulses
//
// state  | meaning
// SERVE  | ball held centred, counting SERVE_FRAMES ticks
// PLAY   | ball moves once per tick
// POINT  | one clk, scoring pulse high; then re-centre and serve
module ball_engine #(
  parameter int W                = 10,
  parameter int X_MAX            = 639,
  parameter int Y_MAX            = 479,
  parameter int BALL_SIZE        = 10,
  parameter int V_INIT           = 1,
  parameter int V_MAX            = 4,
  parameter int HITS_PER_SPEEDUP = 4,
  parameter int SERVE_FRAMES     = 60,
  parameter int TICK_Y           = 481
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [W-1:0] x_i,
  input  logic [W-1:0] y_i,
  input  logic         pause_i,
  input  logic [W-1:0] padl_t_i,
  input  logic [W-1:0] padl_b_i,
  input  logic [W-1:0] padl_l_i,
  input  logic [W-1:0] padl_r_i,
  input  logic [W-1:0] padr_t_i,
  input  logic [W-1:0] padr_b_i,
  input  logic [W-1:0] padr_l_i,
  input  logic [W-1:0] padr_r_i,
  output logic         ball_on_o,
  output logic [W-1:0] ball_x_o,
  output logic [W-1:0] ball_y_o,
  output logic [2:0]   speed_o,
  output logic [1:0]   state_o,
  output logic         score_l_o,
  output logic         score_r_o
);

  localparam int SW  = W + 2;
  localparam int BR  = BALL_SIZE - 1;
  localparam int CX  = (X_MAX + 1 - BALL_SIZE) / 2;
  localparam int CY  = (Y_MAX + 1 - BALL_SIZE) / 2;
  localparam int SCW = $clog2(SERVE_FRAMES + 1);
  localparam int HCW = $clog2(HITS_PER_SPEEDUP + 1);

  localparam logic signed [SW-1:0] BR_S   = SW'(BR);
  localparam logic signed [SW-1:0] BSZ_S  = SW'(BALL_SIZE);
  localparam logic signed [SW-1:0] HALF_S = SW'(BALL_SIZE / 2);
  localparam logic signed [SW-1:0] XMAX_S = SW'(X_MAX);
  localparam logic signed [SW-1:0] YMAX_S = SW'(Y_MAX);

  typedef enum logic [1:0] {S_SERVE = 2'd0, S_PLAY = 2'd1, S_POINT = 2'd2} state_t;

  state_t         state_q, state_d;
  logic [W-1:0]   bx_q, bx_d, by_q, by_d;
  logic           vx_neg_q, vx_neg_d, vy_neg_q, vy_neg_d;
  logic [2:0]     vy_mag_q, vy_mag_d, speed_q, speed_d;
  logic [SCW-1:0] serve_cnt_q, serve_cnt_d;
  logic [HCW-1:0] hit_cnt_q, hit_cnt_d;
  logic           score_l_q, score_l_d, score_r_q, score_r_d;

  function automatic logic signed [SW-1:0] ext(input logic [W-1:0] v);
    return $signed({2'b00, v});
  endfunction

  logic                 tick;
  logic signed [SW-1:0] bx_s, by_s, spd, vym, nx, ny;
  logic                 ovl_l, ovl_r, hit_l, hit_r;
  logic signed [SW-1:0] pad_t, pad_h, pad_h3, cen_off;
  logic                 third_top, third_bot;

  assign tick = (y_i == W'(TICK_Y)) && (x_i == '0) && !pause_i;

  assign bx_s = ext(bx_q);
  assign by_s = ext(by_q);
  assign spd  = SW'(speed_q);
  assign vym  = SW'(vy_mag_q);
  assign nx   = vx_neg_q ? bx_s - spd : bx_s + spd;
  assign ny   = vy_neg_q ? by_s - vym : by_s + vym;

  // Paddle overlap uses the current (pre-move) vertical position.
  assign ovl_r = (by_s <= ext(padr_b_i)) && (by_s + BR_S >= ext(padr_t_i));
  assign ovl_l = (by_s <= ext(padl_b_i)) && (by_s + BR_S >= ext(padl_t_i));
  assign hit_r = !vx_neg_q && (nx + BR_S >= ext(padr_l_i)) && (bx_s <= ext(padr_r_i)) && ovl_r;
  assign hit_l = vx_neg_q && (nx <= ext(padl_r_i)) && (bx_s + BR_S >= ext(padl_l_i)) && ovl_l;

  // Ball centre relative to the struck paddle's top; a centre above the
  // paddle counts as top third, below it as bottom third.
  assign pad_t     = hit_r ? ext(padr_t_i) : ext(padl_t_i);
  assign pad_h     = (hit_r ? ext(padr_b_i) : ext(padl_b_i)) - pad_t + SW'(1);
  assign pad_h3    = pad_h / SW'(3);
  assign cen_off   = by_s + HALF_S - pad_t;
  assign third_top = cen_off < pad_h3;
  assign third_bot = cen_off >= (pad_h3 + pad_h3);

  always_comb begin
    state_d     = state_q;
    bx_d        = bx_q;
    by_d        = by_q;
    vx_neg_d    = vx_neg_q;
    vy_neg_d    = vy_neg_q;
    vy_mag_d    = vy_mag_q;
    speed_d     = speed_q;
    serve_cnt_d = serve_cnt_q;
    hit_cnt_d   = hit_cnt_q;
    score_l_d   = 1'b0;
    score_r_d   = 1'b0;
    case (state_q)
      S_SERVE: begin
        if (tick) begin
          if (serve_cnt_q == SCW'(SERVE_FRAMES - 1)) begin
            state_d     = S_PLAY;
            serve_cnt_d = '0;
          end else begin
            serve_cnt_d = serve_cnt_q + SCW'(1);
          end
        end
      end
      S_PLAY: begin
        if (tick) begin
          if (ny[SW-1]) begin
            by_d     = '0;
            vy_neg_d = 1'b0;
          end else if (ny + BR_S > YMAX_S) begin
            by_d     = W'(Y_MAX - BR);
            vy_neg_d = 1'b1;
          end else begin
            by_d = W'(ny);
          end
          if (hit_r || hit_l) begin
            if (hit_r) begin
              bx_d     = W'(ext(padr_l_i) - BSZ_S);
              vx_neg_d = 1'b1;
            end else begin
              bx_d     = padl_r_i + W'(1);
              vx_neg_d = 1'b0;
            end
            // Top/bottom thirds override any wall sign flip; middle keeps it.
            if (third_top) begin
              vy_neg_d = 1'b1;
              vy_mag_d = speed_q;
            end else if (third_bot) begin
              vy_neg_d = 1'b0;
              vy_mag_d = speed_q;
            end else begin
              vy_mag_d = 3'd1;
            end
            if (hit_cnt_q == HCW'(HITS_PER_SPEEDUP - 1)) begin
              hit_cnt_d = '0;
              speed_d   = (speed_q >= 3'(V_MAX)) ? 3'(V_MAX) : speed_q + 3'd1;
            end else begin
              hit_cnt_d = hit_cnt_q + HCW'(1);
            end
          end else if (nx + BR_S > XMAX_S) begin
            state_d   = S_POINT;
            score_l_d = 1'b1;
          end else if (nx[SW-1]) begin
            state_d   = S_POINT;
            score_r_d = 1'b1;
          end else begin
            bx_d = W'(nx);
          end
        end
      end
      S_POINT: begin
        state_d     = S_SERVE;
        bx_d        = W'(CX);
        by_d        = W'(CY);
        speed_d     = 3'(V_INIT);
        hit_cnt_d   = '0;
        serve_cnt_d = '0;
        // Serve toward the player who conceded.
        vx_neg_d    = score_r_q;
        vy_neg_d    = 1'b0;
        vy_mag_d    = 3'd1;
      end
      default: state_d = S_SERVE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= S_SERVE;
      bx_q        <= W'(CX);
      by_q        <= W'(CY);
      vx_neg_q    <= 1'b0;
      vy_neg_q    <= 1'b0;
      vy_mag_q    <= 3'd1;
      speed_q     <= 3'(V_INIT);
      serve_cnt_q <= '0;
      hit_cnt_q   <= '0;
      score_l_q   <= 1'b0;
      score_r_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      bx_q        <= bx_d;
      by_q        <= by_d;
      vx_neg_q    <= vx_neg_d;
      vy_neg_q    <= vy_neg_d;
      vy_mag_q    <= vy_mag_d;
      speed_q     <= speed_d;
      serve_cnt_q <= serve_cnt_d;
      hit_cnt_q   <= hit_cnt_d;
      score_l_q   <= score_l_d;
      score_r_q   <= score_r_d;
    end
  end

  assign ball_on_o = ({1'b0, x_i} >= {1'b0, bx_q}) && ({1'b0, x_i} <= {1'b0, bx_q} + (W+1)'(BR)) &&
                     ({1'b0, y_i} >= {1'b0, by_q}) && ({1'b0, y_i} <= {1'b0, by_q} + (W+1)'(BR));
  assign ball_x_o  = bx_q;
  assign ball_y_o  = by_q;
  assign speed_o   = speed_q;
  assign state_o   = state_q;
  assign score_l_o = score_l_q;
  assign score_r_o = score_r_q;

endmodule

// File: tb/tb_ball_engine.sv
module tb_ball_engine;
  localparam int W = 10;

  logic clk = 1'b0;
  logic reset;
  logic [W-1:0] x, y;
  logic pause;
  logic [W-1:0] padl_t, padl_b, padl_l, padl_r, padr_t, padr_b, padr_l, padr_r;
  logic ball_on;
  logic [W-1:0] ball_x, ball_y;
  logic [2:0] speed;
  logic [1:0] state;
  logic score_l, score_r;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  ball_engine dut (
    .clk(clk), .reset(reset), .x_i(x), .y_i(y), .pause_i(pause),
    .padl_t_i(padl_t), .padl_b_i(padl_b), .padl_l_i(padl_l), .padl_r_i(padl_r),
    .padr_t_i(padr_t), .padr_b_i(padr_b), .padr_l_i(padr_l), .padr_r_i(padr_r),
    .ball_on_o(ball_on), .ball_x_o(ball_x), .ball_y_o(ball_y), .speed_o(speed),
    .state_o(state), .score_l_o(score_l), .score_r_o(score_r)
  );

  // One frame tick: registered on this edge, outputs sampled 1ns later.
  task automatic do_tick();
    x = '0; y = 10'd481;
    @(posedge clk); #1;
    y = '0;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) do_tick();
  endtask

  task automatic idle();
    @(posedge clk); #1;
  endtask

  task automatic no_paddles();
    padl_t = 10'd1000; padl_b = 10'd1000; padl_l = '0; padl_r = '0;
    padr_t = 10'd1000; padr_b = 10'd1000; padr_l = '0; padr_r = '0;
  endtask

  // Reset and run through the full serve; returns with the ball in PLAY at centre.
  task automatic restart();
    pause = 1'b0;
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    ticks(60);
  endtask

  task automatic test_reset();
    reset = 1'b1; pause = 1'b0; no_paddles();
    x = 10'd315; y = 10'd235;
    #12;
    checks++; if (ball_x !== 10'd315) begin failures++; $display("FAIL rst_ball_x got=%0d exp=315", ball_x); end
    checks++; if (ball_y !== 10'd235) begin failures++; $display("FAIL rst_ball_y got=%0d exp=235", ball_y); end
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL rst_state got=%0d exp=0", state); end
    checks++; if (speed !== 3'd1) begin failures++; $display("FAIL rst_speed got=%0d exp=1", speed); end
    checks++; if (score_l !== 1'b0 || score_r !== 1'b0) begin failures++; $display("FAIL rst_scores got=%b%b exp=00", score_l, score_r); end
    checks++; if (ball_on !== 1'b1) begin failures++; $display("FAIL rst_on_corner_tl got=%b exp=1", ball_on); end
    x = 10'd324; y = 10'd244; #1;
    checks++; if (ball_on !== 1'b1) begin failures++; $display("FAIL rst_on_corner_br got=%b exp=1", ball_on); end
    x = 10'd325; #1;
    checks++; if (ball_on !== 1'b0) begin failures++; $display("FAIL rst_on_outside got=%b exp=0", ball_on); end
    @(posedge clk); #1;
    reset = 1'b0; x = '0; y = '0;
  endtask

  task automatic test_serve_pause();
    ticks(30);
    pause = 1'b1; ticks(10); pause = 1'b0;
    ticks(29);
    checks++; if (state !== 2'd0) begin failures++; $display("FAIL serve_59_state got=%0d exp=0", state); end
    do_tick();
    checks++; if (state !== 2'd1) begin failures++; $display("FAIL serve_60_state got=%0d exp=1", state); end
    checks++; if (ball_x !== 10'd315) begin failures++; $display("FAIL serve_60_x got=%0d exp=315", ball_x); end
    do_tick();
    checks++; if (ball_x !== 10'd316 || ball_y !== 10'd236) begin failures++; $display("FAIL first_move got=%0d,%0d exp=316,236", ball_x, ball_y); end
  endtask

  // Continues from play tick 1 with no paddles: bottom wall, pause, right exit.
  task automatic test_pause_wall_exit_right();
    for (int k = 2; k <= 316; k++) begin
      do_tick();
      if (k == 100) begin
        checks++; if (ball_x !== 10'd415 || ball_y !== 10'd335) begin failures++; $display("FAIL play_k100 got=%0d,%0d exp=415,335", ball_x, ball_y); end
        pause = 1'b1; ticks(10); pause = 1'b0;
        checks++; if (ball_x !== 10'd415 || ball_y !== 10'd335) begin failures++; $display("FAIL pause_frozen got=%0d,%0d exp=415,335", ball_x, ball_y); end
      end
      if (k == 236) begin
        checks++; if (ball_y !== 10'd470) begin failures++; $display("FAIL wall_bot_clamp got=%0d exp=470", ball_y); end
      end
      if (k == 237) begin
        checks++; if (ball_y !== 10'd469 || ball_x !== 10'd552) begin failures++; $display("FAIL wall_bot_after got=%0d,%0d exp=552,469", ball_x, ball_y); end
      end
      if (k == 315) begin
        checks++; if (state !== 2'd1 || ball_x !== 10'd630 || ball_y !== 10'd391) begin failures++; $display("FAIL pre_exit got=s%0d %0d,%0d exp=s1 630,391", state, ball_x, ball_y); end
      end
    end
    checks++; if (state !== 2'd2 || score_l !== 1'b1 || score_r !== 1'b0) begin failures++; $display("FAIL exit_r_point got=s%0d l%b r%b exp=s2 l1 r0", state, score_l, score_r); end
    idle();
    checks++; if (state !== 2'd0 || score_l !== 1'b0) begin failures++; $display("FAIL exit_r_serve got=s%0d l%b exp=s0 l0", state, score_l); end
    checks++; if (ball_x !== 10'd315 || ball_y !== 10'd235 || speed !== 3'd1) begin failures++; $display("FAIL exit_r_centre got=%0d,%0d v%0d exp=315,235 v1", ball_x, ball_y, speed); end
    ticks(60);
    do_tick();
    checks++; if (ball_x !== 10'd316) begin failures++; $display("FAIL exit_r_reserve_dir got=%0d exp=316", ball_x); end
  endtask

  task automatic test_deflect_top_wall_exit_left();
    no_paddles();
    padr_l = 10'd340; padr_r = 10'd349; padr_t = 10'd250; padr_b = 10'd279;
    restart();
    for (int k = 1; k <= 347; k++) begin
      do_tick();
      if (k == 15) begin
        checks++; if (ball_x !== 10'd330 || ball_y !== 10'd250) begin failures++; $display("FAIL defl_pre got=%0d,%0d exp=330,250", ball_x, ball_y); end
      end
      if (k == 16) begin
        checks++; if (ball_x !== 10'd330 || ball_y !== 10'd251 || state !== 2'd1) begin failures++; $display("FAIL defl_hit got=%0d,%0d s%0d exp=330,251 s1", ball_x, ball_y, state); end
      end
      if (k == 17) begin
        checks++; if (ball_x !== 10'd329 || ball_y !== 10'd250) begin failures++; $display("FAIL defl_top_third got=%0d,%0d exp=329,250", ball_x, ball_y); end
      end
      if (k == 268) begin
        checks++; if (ball_y !== 10'd0) begin failures++; $display("FAIL wall_top_clamp got=%0d exp=0", ball_y); end
      end
      if (k == 269) begin
        checks++; if (ball_y !== 10'd1 || ball_x !== 10'd77) begin failures++; $display("FAIL wall_top_after got=%0d,%0d exp=77,1", ball_x, ball_y); end
      end
      if (k == 346) begin
        checks++; if (ball_x !== 10'd0 || state !== 2'd1) begin failures++; $display("FAIL pre_exit_l got=%0d s%0d exp=0 s1", ball_x, state); end
      end
    end
    checks++; if (state !== 2'd2 || score_r !== 1'b1 || score_l !== 1'b0) begin failures++; $display("FAIL exit_l_point got=s%0d l%b r%b exp=s2 l0 r1", state, score_l, score_r); end
    idle();
    checks++; if (score_r !== 1'b0 || state !== 2'd0) begin failures++; $display("FAIL exit_l_pulse_width got=r%b s%0d exp=r0 s0", score_r, state); end
    ticks(60);
    do_tick();
    checks++; if (ball_x !== 10'd314 || ball_y !== 10'd236) begin failures++; $display("FAIL exit_l_reserve_dir got=%0d,%0d exp=314,236", ball_x, ball_y); end
  endtask

  task automatic test_speed_ramp();
    padl_l = 10'd291; padl_r = 10'd300; padl_t = 10'd0; padl_b = 10'd479;
    padr_l = 10'd340; padr_r = 10'd349; padr_t = 10'd0; padr_b = 10'd479;
    restart();
    for (int k = 1; k <= 238; k++) begin
      do_tick();
      if (k == 16) begin
        checks++; if (ball_x !== 10'd330 || speed !== 3'd1) begin failures++; $display("FAIL ramp_hit1 got=%0d v%0d exp=330 v1", ball_x, speed); end
      end
      if (k == 105) begin
        checks++; if (speed !== 3'd1) begin failures++; $display("FAIL ramp_pre4 got=%0d exp=1", speed); end
      end
      if (k == 106) begin
        checks++; if (speed !== 3'd2 || ball_x !== 10'd301) begin failures++; $display("FAIL ramp_hit4 got=v%0d %0d exp=v2 301", speed, ball_x); end
      end
      if (k == 165) begin
        checks++; if (speed !== 3'd2) begin failures++; $display("FAIL ramp_pre8 got=%0d exp=2", speed); end
      end
      if (k == 166) begin
        checks++; if (speed !== 3'd3) begin failures++; $display("FAIL ramp_hit8 got=%0d exp=3", speed); end
      end
      if (k == 206) begin
        checks++; if (speed !== 3'd4) begin failures++; $display("FAIL ramp_hit12 got=%0d exp=4", speed); end
      end
    end
    checks++; if (speed !== 3'd4 || ball_x !== 10'd301) begin failures++; $display("FAIL ramp_cap got=v%0d %0d exp=v4 301", speed, ball_x); end
    padr_t = 10'd1000; padr_b = 10'd1000;
    for (int k = 239; k <= 321; k++) begin
      do_tick();
      if (k == 320) begin
        checks++; if (ball_x !== 10'd629 || state !== 2'd1) begin failures++; $display("FAIL fast_pre_exit got=%0d s%0d exp=629 s1", ball_x, state); end
      end
    end
    checks++; if (state !== 2'd2 || score_l !== 1'b1) begin failures++; $display("FAIL fast_exit got=s%0d l%b exp=s2 l1", state, score_l); end
    idle();
    checks++; if (speed !== 3'd1 || state !== 2'd0) begin failures++; $display("FAIL fast_speed_reset got=v%0d s%0d exp=v1 s0", speed, state); end
  endtask

  task automatic test_hit_beats_exit_reset_in_point();
    no_paddles();
    padr_l = 10'd640; padr_r = 10'd649; padr_t = 10'd0; padr_b = 10'd1000;
    restart();
    for (int k = 1; k <= 947; k++) begin
      do_tick();
      if (k == 316) begin
        checks++; if (ball_x !== 10'd630 || state !== 2'd1 || score_l !== 1'b0) begin failures++; $display("FAIL hit_suppress got=%0d s%0d l%b exp=630 s1 l0", ball_x, state, score_l); end
      end
      if (k == 317) begin
        checks++; if (ball_x !== 10'd629) begin failures++; $display("FAIL hit_suppress_after got=%0d exp=629", ball_x); end
      end
      if (k == 946) begin
        checks++; if (ball_x !== 10'd0) begin failures++; $display("FAIL long_pre_exit got=%0d exp=0", ball_x); end
      end
    end
    checks++; if (state !== 2'd2 || score_r !== 1'b1 || score_l !== 1'b0) begin failures++; $display("FAIL long_exit got=s%0d l%b r%b exp=s2 l0 r1", state, score_l, score_r); end
    #1 reset = 1'b1;
    #2;
    checks++; if (score_r !== 1'b0 || state !== 2'd0) begin failures++; $display("FAIL rst_in_point got=r%b s%0d exp=r0 s0", score_r, state); end
    checks++; if (ball_x !== 10'd315 || ball_y !== 10'd235 || speed !== 3'd1) begin failures++; $display("FAIL rst_in_point_pos got=%0d,%0d v%0d exp=315,235 v1", ball_x, ball_y, speed); end
    reset = 1'b0;
    idle();
  endtask

  initial begin
    x = '0; y = '0;
    test_reset();
    test_serve_pause();
    test_pause_wall_exit_right();
    test_deflect_top_wall_exit_left();
    test_speed_ramp();
    test_hit_beats_exit_reset_in_point();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/ball_engine.md
# ball_engine

Parametrised ball engine for the Pong datapath, succeeding the fixed-size bouncing square. Moves the ball once per frame and bounces it off the top/bottom walls and off both paddles. Deflection angle depends on which third of the paddle is hit, and speed ramps after a set number of paddle hits. Detects misses, emits per-player score pulses and runs a serve/point state machine; sits between the paddle controllers/VGA counters and the pixel mux and score counters.

## Interface
- W, 10: coordinate width (x, y, paddle bounds, ball position)
- X_MAX, 639: rightmost visible column
- Y_MAX, 479: bottom visible row
- BALL_SIZE, 10: ball side in pixels
- V_INIT, 1: speed (pixels/frame) after reset and after every point
- V_MAX, 4: speed ceiling
- HITS_PER_SPEEDUP, 4: paddle hits per speed increment
- SERVE_FRAMES, 60: frames ball is held centred before launch
- TICK_Y, 481: row on which the frame tick fires (with x == 0)

- clk  in  1  system clock
- reset  in  1  asynchronous, active-high
- x, y  in  W each  current pixel from VGA controller
- pause  in  1  high: frame ticks ignored (all state frozen)
- padl_t, padl_b, padl_l, padl_r  in  W each  left paddle bounds, inclusive
- padr_t, padr_b, padr_l, padr_r  in  W each  right paddle bounds, inclusive
- ball_on  out  1  pixel (x,y) inside ball
- ball_x, ball_y  out  W each  ball left/top edge
- speed  out  3  current horizontal speed
- state  out  2  0 SERVE, 1 PLAY, 2 POINT
- score_l, score_r  out  1 each  one-cycle pulse: left/right player scored

## Operation
- tick = (y == TICK_Y) && (x == 0) && !pause; all updates below occur only on tick, except POINT -> SERVE.
- Velocity: vx sign + magnitude speed; vy sign + magnitude in {1, speed}.
- Arithmetic in W+2-bit signed: nx = ball_x ± speed, ny = ball_y ± |vy|; BR = BALL_SIZE-1.
- SERVE: ball at centre CX=(X_MAX+1-BALL_SIZE)/2, CY=(Y_MAX+1-BALL_SIZE)/2; serve counter ++ per tick; at SERVE_FRAMES-1 -> PLAY, counter cleared, first move on next tick.
- PLAY, per tick, evaluated from current registers in this order:
  - Wall: ny < 0 -> ball_y=0, vy positive; ny+BR > Y_MAX -> ball_y=Y_MAX-BR, vy negative; else ball_y=ny.
  - Right paddle (vx>0 only): nx+BR >= padr_l, ball_x <= padr_r, ball vertically overlaps [padr_t,padr_b] -> ball_x=padr_l-BALL_SIZE, vx negative, hit.
  - Left paddle (vx<0 only): mirror; ball_x=padl_r+1, vx positive, hit.
  - Deflection on hit: ball centre (ball_y+BALL_SIZE/2) vs paddle height split in thirds: top third vy=-speed, bottom third vy=+speed, middle vy magnitude 1, sign kept.
  - No hit: nx+BR > X_MAX -> POINT, score_l; nx < 0 -> POINT, score_r; else ball_x=nx.
  - Hit counter ++ per hit; at HITS_PER_SPEEDUP: counter=0, speed=min(speed+1, V_MAX).
- POINT (one clk): scoring pulse high; next clk -> SERVE, ball centred, speed=V_INIT, hit counter 0, vx toward conceding player, vy positive magnitude 1.

## Timing
- Reset values: ball_x=CX, ball_y=CY (315, 235 at defaults), state SERVE, speed V_INIT, vx +, vy +1, counters 0, score_l=score_r=0, ball_on per registers.
- Position/velocity/state registered on the clk edge ending the tick cycle; ball_on combinational from registers and x,y.
- score_l/score_r exactly one clk wide, never both high.
- Simultaneous: wall and paddle in one tick both apply; paddle hit suppresses exit; speedup takes effect next tick.
- Reset asserted mid-frame: immediate return to reset values; no pulse emitted.
- pause in SERVE freezes serve counter; in POINT has no effect.

## Test plan
- Reset, 60 ticks -> state SERVE until 60th tick, then PLAY; ball_x 315 -> 316 on next tick.
- Ball at y=1 moving up at |vy|=2 -> ball_y=0, vy=+2 after one tick.
- Right paddle l=600, t=200, b=259; ball x=589, y=200 moving right -> ball_x=590, vx negative, vy=-speed (top third).
- Four consecutive paddle hits at V_INIT=1 -> speed 2; repeat to speed 4, then further hits keep 4.
- Ball x=635, vx=+1, no paddle -> next tick POINT with score_l pulse for one clk, then SERVE, centred, speed 1, vx positive.
- pause high for 10 frames in PLAY -> ball_x/ball_y unchanged; reset during POINT -> score pulse drops, state SERVE.
